div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle divide controller for the EX stage of the MIPS core. It watches the 8-bit ALU control code, and when that code is DIV or DIVU it latches the operands and runs a 32-iteration restoring division. While it runs it stalls the pipeline, and it releases the stall for exactly one cycle when the 64-bit {HI, LO} result is valid. It also aborts cleanly when the EX stage is flushed by an exception.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `alucontrol`  in  8  EX-stage ALU control code. `EXE_DIV_OP` starts a signed divide; `EXE_DIVU_OP` starts an unsigned divide.
- `opdata1`  in  WIDTH  dividend (rs value).
- `opdata2`  in  WIDTH  divisor (rt value).
- `annul`  in  1  EX flush (exception or eret); cancels any divide in progress.
- `stall_req`  out  1  pipeline stall request (combinational).
- `ready`  out  1  result valid; high only in state DONE.
- `hi`  out  WIDTH  remainder, registered.
- `lo`  out  WIDTH  quotient, registered.

## Operation
Definitions:
- `is_div` = (`alucontrol` == `EXE_DIV_OP`) || (`alucontrol` == `EXE_DIVU_OP`).
- `sgn` = (`alucontrol` == `EXE_DIV_OP`), latched at start.

States and transitions:
- **IDLE**
  - If `is_div` && !`annul` and `opdata2` == 0: go to BYZERO.
  - If `is_div` && !`annul` and `opdata2` != 0: latch `sgn`, latch |`opdata1`| and |`opdata2`| (absolute value only when `sgn`; 0x80000000 is kept as the unsigned magnitude), latch both operand sign bits, clear the partial remainder, set `cnt` = 0, go to BUSY.
  - Otherwise: stay in IDLE.
- **BUSY**
  - Each cycle performs one restoring step: shift the {remainder, dividend} pair left by 1, then trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit.
  - `cnt` increments each cycle. After the step with `cnt` == WIDTH-1, go to DONE.
- **BYZERO**: one cycle, then go to DONE with a forced result of `hi` = 0, `lo` = 0.
- **DONE**
  - Load `hi`/`lo` at entry. When `sgn` is set, apply sign fixes: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Always return to IDLE on the next edge, so back-to-back divides restart from IDLE.

Outputs and boundary conditions:
- `stall_req` = `is_div` && (state != DONE) && !`annul`.
- `ready` = (state == DONE).
- Operands are sampled only in IDLE; later changes on `opdata1`/`opdata2` are ignored.
- `annul` in BUSY or BYZERO: go to IDLE on the next edge. No `ready` pulse; `hi`/`lo` are unchanged.
- `annul` in DONE: no effect; the transition to IDLE happens anyway.
- Reset (asynchronous, including mid-operation): state = IDLE, `cnt` = 0, `hi` = `lo` = 0, all internal registers cleared. This gives `ready` = 0 and `stall_req` = `is_div`.

## Timing
Take cycle 0 as the first cycle in which `is_div` is high in IDLE.
- **Normal divide**
  - `stall_req` is high in cycles 0..32.
  - State is BUSY in cycles 1..32.
  - In cycle 33: state is DONE, `ready` = 1, `stall_req` = 0, and `hi`/`lo` are valid. The EX/MEM register captures them at the end of cycle 33.
- **Divide by zero**: BYZERO in cycle 1, DONE/`ready` in cycle 2.
- **Back-to-back divides**: the next divide's cycle 0 is cycle 34.
- **Throughput**: one divide per 34 cycles.
- `hi` and `lo` hold their value until the next DONE.

## Structure
- Put these in `defines.vh`:
  - state encodings `DIV_IDLE`, `DIV_BYZERO`, `DIV_BUSY`, `DIV_DONE` (2 bits);
  - the existing `EXE_DIV_OP` / `EXE_DIVU_OP` codes.
- Sub-module `div_step` (combinational): one restoring iteration.
  - Inputs: {remainder, dividend} and divisor.
  - Outputs: the next pair and the quotient bit.
- The FSM, counter and sign fixes stay in `div_ctrl`.

## Test plan
- DIVU 100 / 7 → at cycle 33: `ready` = 1, `lo` = 14, `hi` = 2; `stall_req` high for exactly 33 cycles.
- DIV -7 / 2 (0xFFFFFFF9 / 0x2) → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0. DIVU 0xFFFFFFFF / 1 → `lo` = 0xFFFFFFFF, `hi` = 0.
- DIVU 5 / 0 → BYZERO in cycle 1, `ready` in cycle 2, `hi` = `lo` = 0.
- DIVU 100 / 7 with `annul` in cycle 10 → state IDLE in cycle 11, no `ready` pulse, `hi`/`lo` keep their prior values. Also: `resetn` low in cycle 20 → immediate IDLE, outputs 0.
- Back-to-back DIVU 9/2 then DIV -9/2 → first `ready` in cycle 33 (`lo` = 4, `hi` = 1); second `ready` in cycle 67 (`lo` = 0xFFFFFFFC, `hi` = 0xFFFFFFFF).

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide controller:
// ALU control codes and the FSM state encoding.
package div_ctrl_pkg;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_BUSY   = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] code);
    return (code == EXE_DIV_OP) || (code == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divide controller bundle: request side from the pipeline,
// stall/result side back from the divider.
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       alucontrol;
    logic [WIDTH-1:0] opdata1;
    logic [WIDTH-1:0] opdata2;
    logic             annul;
    logic             stall_req;
    logic             ready;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output alucontrol, opdata1, opdata2, annul,
        input  stall_req, ready, hi, lo
    );

    modport slave (
        input  alucontrol, opdata1, opdata2, annul,
        output stall_req, ready, hi, lo
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on a {remainder, dividend} pair.
// pair_o leaves the quotient slot (bit 0) clear; the caller inserts q_bit_o.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] pair_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] pair_o,
    output logic               q_bit_o
);
    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;

    // The shifted remainder needs WIDTH+1 bits: it can reach 2*divisor-1.
    assign shifted_rem = pair_i[2*WIDTH-1:WIDTH-1];
    assign trial       = shifted_rem - {1'b0, divisor_i};
    assign q_bit_o     = ~trial[WIDTH];
    assign pair_o      = {(q_bit_o ? trial[WIDTH-1:0] : shifted_rem[WIDTH-1:0]),
                          pair_i[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divide controller for the EX stage: stalls the
// pipeline for WIDTH restoring steps and presents {hi, lo} for one cycle.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     resetn,
    div_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] pair_q, pair_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_div;
    logic               start_sgn;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH-1:0] step_pair, step_next;
    logic               step_q;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_div    = is_div_op(bus.alucontrol);
    assign start_sgn = (bus.alucontrol == EXE_DIV_OP);
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign mag1 = (start_sgn && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
    assign mag2 = (start_sgn && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

    div_step #(.WIDTH(WIDTH)) u_step (
        .pair_i    (pair_q),
        .divisor_i (divisor_q),
        .pair_o    (step_pair),
        .q_bit_o   (step_q)
    );

    assign step_next = step_pair | {{(2*WIDTH-1){1'b0}}, step_q};
    assign quo_fix   = (sgn_q && neg_quo_q) ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    assign rem_fix   = (sgn_q && neg_rem_q) ? -step_next[2*WIDTH-1:WIDTH]
                                            :  step_next[2*WIDTH-1:WIDTH];

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        pair_d    = pair_q;
        divisor_d = divisor_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            DIV_IDLE: begin
                if (is_div && !bus.annul) begin
                    if (bus.opdata2 == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d   = DIV_BUSY;
                        sgn_d     = start_sgn;
                        neg_quo_d = bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1];
                        neg_rem_d = bus.opdata1[WIDTH-1];
                        pair_d    = {{WIDTH{1'b0}}, mag1};
                        divisor_d = mag2;
                        cnt_d     = '0;
                    end
                end
            end
            DIV_BUSY: begin
                if (bus.annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    pair_d = step_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DIV_DONE;
                        hi_d    = rem_fix;
                        lo_d    = quo_fix;
                    end
                end
            end
            DIV_BYZERO: begin
                if (bus.annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_DONE;
                    hi_d    = '0;
                    lo_d    = '0;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; every register, datapath included, is reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            pair_q    <= '0;
            divisor_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            pair_q    <= pair_d;
            divisor_q <= divisor_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.stall_req = is_div && (state_q != DIV_DONE) && !bus.annul;
    assign bus.ready     = (state_q == DIV_DONE);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a driver pushes hand-computed {hi, lo} results
// into a queue, and a monitor pops and compares on every ready pulse.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic clk;
    logic resetn;
    int   n_chk = 0;
    int   n_err = 0;
    logic [63:0] exp_q[$];

    div_ctrl_if #(.WIDTH(32)) bus ();

    div_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (resetn && bus.ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
                check("lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic launch(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.alucontrol = op;
        bus.opdata1    = a;
        bus.opdata2    = b;
    endtask

    // Counts cycles from the current one (cycle 0) until ready is seen.
    task automatic wait_ready(input bit scramble, output int cyc, output int stalls);
        cyc    = -1;
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                cyc = i;
                check("stall_at_done", {63'd0, bus.stall_req}, 64'd0);
                return;
            end
            if (bus.stall_req) stalls++;
            if (scramble && i == 1) begin
                bus.opdata1 = $urandom;
                bus.opdata2 = $urandom;
            end
        end
        check("ready_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_div(input string name, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input int exp_cyc, input int exp_stall, input bit scramble);
        int cyc, stalls;
        launch(op, a, b);
        exp_q.push_back({ehi, elo});
        wait_ready(scramble, cyc, stalls);
        check({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
        check({name, "_stalls"}, 64'(stalls), 64'(exp_stall));
        bus.alucontrol = EXE_NOP_OP;
    endtask

    initial begin
        int cyc, stalls;
        resetn         = 1'b1;
        bus.alucontrol = EXE_NOP_OP;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.annul      = 1'b0;
        #2 resetn = 1'b0;

        @(negedge clk);
        check("rst_ready", {63'd0, bus.ready}, 64'd0);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        check("rst_stall_nop", {63'd0, bus.stall_req}, 64'd0);
        bus.alucontrol = EXE_DIV_OP;
        #1 check("rst_stall_div", {63'd0, bus.stall_req}, 64'd1);
        bus.alucontrol = EXE_NOP_OP;
        @(posedge clk);
        #1 resetn = 1'b1;

        run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 33, 33, 1'b0);
        run_div("divu_by0", EXE_DIVU_OP, 32'd5, 32'd0, 32'd0, 32'd0, 2, 2, 1'b0);
        run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33, 1'b1);
        run_div("div_min_m1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF,
                32'd0, 32'h8000_0000, 33, 33, 1'b1);
        run_div("divu_max_1", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1,
                32'd0, 32'hFFFF_FFFF, 33, 33, 1'b0);

        // Back-to-back: the second divide is presented in the first one's DONE cycle.
        launch(EXE_DIVU_OP, 32'd9, 32'd2);
        exp_q.push_back({32'd1, 32'd4});
        wait_ready(1'b0, cyc, stalls);
        check("b2b_first_latency", 64'(cyc), 64'd33);
        bus.alucontrol = EXE_DIV_OP;
        bus.opdata1    = 32'hFFFF_FFF7;
        bus.opdata2    = 32'd2;
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFC});
        wait_ready(1'b0, cyc, stalls);
        check("b2b_second_latency", 64'(34 + cyc), 64'd67);
        check("b2b_second_stalls", 64'(stalls), 64'd33);
        bus.alucontrol = EXE_NOP_OP;

        // Annul in cycle 10, then restart from IDLE in cycle 11.
        launch(EXE_DIVU_OP, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) @(negedge clk);
        @(posedge clk);
        #1 bus.annul = 1'b1;
        @(negedge clk);
        check("annul_stall", {63'd0, bus.stall_req}, 64'd0);
        check("annul_ready", {63'd0, bus.ready}, 64'd0);
        check("annul_hi_hold", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
        check("annul_lo_hold", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFC);
        @(posedge clk);
        #1 bus.annul = 1'b0;
        exp_q.push_back({32'd2, 32'd14});
        wait_ready(1'b0, cyc, stalls);
        check("annul_restart_latency", 64'(cyc), 64'd33);
        bus.alucontrol = EXE_NOP_OP;

        // Asynchronous reset in cycle 20 of a running divide.
        launch(EXE_DIVU_OP, 32'd1000, 32'd3);
        for (int i = 0; i < 20; i++) @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst_ready", {63'd0, bus.ready}, 64'd0);
        check("midrst_hi", {32'd0, bus.hi}, 64'd0);
        check("midrst_lo", {32'd0, bus.lo}, 64'd0);
        check("midrst_stall", {63'd0, bus.stall_req}, 64'd1);
        bus.alucontrol = EXE_NOP_OP;
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 40; i++) @(negedge clk);
        check("post_rst_lo", {32'd0, bus.lo}, 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
